// File: rtl/simple_uart_pkg.sv
// Shared UART constants so the rx, tx and fifo blocks agree on word size and
// timing defaults, plus the feeder FSM encoding.
package simple_uart_pkg;

    localparam int UART_NUM_BITS = 8;
    localparam int SYSTEM_FREQ   = 50_000_000;
    localparam int BAUD_RATE     = 115_200;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

endpackage

// File: rtl/simple_uart_tx_fifo_if.sv
// Producer-side byte handshake and UART-side load/done handshake of the TX feeder.
// The slave modport is the feeder's own view; master is the surrounding logic.
interface simple_uart_tx_fifo_if
    import simple_uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_NUM_BITS
);

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] tx_value;
    logic                  tx_value_write;
    logic                  tx_value_done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  tx_value,
        input  tx_value_write,
        output tx_value_done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output tx_value,
        output tx_value_write,
        input  tx_value_done
    );

endinterface

// File: rtl/simple_fifo_sync.sv
// Single-clock FIFO with registered level/full/empty; read data is the entry at
// the read pointer, so the consumer captures it on the same edge it pops.
module simple_fifo_sync #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clock,
    input  logic                         srst,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         empty,
    output logic                         full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             do_push;
    logic             do_pop;

    // Requests are gated by the registered flags, so a push while full or a
    // pop while empty is silently dropped.
    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_W'(DEPTH));
    end

    always_ff @(posedge clock) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign level   = level_q;
    assign empty   = empty_q;
    assign full    = full_q;

endmodule

// File: rtl/simple_uart_tx_fifo.sv
// Byte queue in front of simple_uart_tx: buffers producer bytes and hands them
// to the transmitter one frame at a time via the load/done handshake.
module simple_uart_tx_fifo
    import simple_uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = UART_NUM_BITS
) (
    input  logic                        clock,
    input  logic                        srst,
    simple_uart_tx_fifo_if.slave        bus,
    output logic [$clog2(DEPTH+1)-1:0]  level,
    output logic                        empty,
    output logic                        full,
    output logic                        busy
);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_value_q, tx_value_d;
    logic                  tx_value_write_q, tx_value_write_d;

    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic                  fifo_full;

    simple_fifo_sync #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clock   (clock),
        .srst    (srst),
        .push    (bus.in_valid),
        .wr_data (bus.in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .level   (level),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // The pop and the tx_value load share one edge; the strobe is registered
    // so it is high for exactly the ISSUE cycle that follows.
    always_comb begin
        state_d          = state_q;
        tx_value_d       = tx_value_q;
        tx_value_write_d = 1'b0;
        fifo_pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop         = 1'b1;
                    tx_value_d       = fifo_rd_data;
                    tx_value_write_d = 1'b1;
                    state_d          = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.tx_value_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (srst) begin
            state_q          <= ST_IDLE;
            tx_value_q       <= '0;
            tx_value_write_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            tx_value_q       <= tx_value_d;
            tx_value_write_q <= tx_value_write_d;
        end
    end

    assign bus.in_ready       = !fifo_full;
    assign bus.tx_value       = tx_value_q;
    assign bus.tx_value_write = tx_value_write_q;

    assign empty = fifo_empty;
    assign full  = fifo_full;
    assign busy  = (state_q != ST_IDLE) || !fifo_empty;

endmodule
